// File: rtl/sq_operand_sched_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sq_sched_pkg
// Description : Shared state encoding and elaboration-time helpers for the
//               square/multiply operand sequencer. npairs() gives the number
//               of segment pairs issued for a given mode. pair_at() gives the
//               (i,j) pair at a given position in issue order, which is:
//               descending weight i+j; within one weight the square pair
//               (i==j) comes first, then descending i.
// Revision    : 1.0  initial release
// ============================================================================
package sq_sched_pkg;

  typedef logic [1:0] sched_state_t;

  localparam sched_state_t c_st_idle  = 2'd0;
  localparam sched_state_t c_st_issue = 2'd1;
  localparam sched_state_t c_st_done  = 2'd2;

  // Square mode keeps only i>=j; multiply mode keeps every (i,j).
  function automatic int npairs(input int nseg, input bit sq);
    return sq ? (nseg * (nseg + 1)) / 2 : nseg * nseg;
  endfunction

  // Returns {i[15:0], j[15:0]}. Positions past the end return {0,0}.
  function automatic logic [31:0] pair_at(input int idx, input int nseg, input bit sq);
    int          n;
    int          j;
    logic [31:0] res;
    n   = 0;
    res = '0;
    for (int s = 2 * (nseg - 1); s >= 0; s--) begin
      if ((s % 2) == 0) begin
        if (n == idx) res = {16'(s / 2), 16'(s / 2)};
        n++;
      end
      for (int i = nseg - 1; i >= 0; i--) begin
        j = s - i;
        if (j >= 0 && j < nseg && i != j && (!sq || i > j)) begin
          if (n == idx) res = {16'(i), 16'(j)};
          n++;
        end
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sq_operand_sched_if.sv
`default_nettype none
// ============================================================================
// Interface   : sq_operand_sched_if
// Description : Operand/start handshake plus the beat-issue bus between the
//               sequencer and the multiplier array.
//               slave  : sequencer side (takes start/operands/out_ready,
//                        drives start_rdy, beat data, last, done)
//               master : requester/consumer side (mirror image)
//   start/start_rdy   operation request handshake
//   op_sq, op_a, op_b operands and mode, sampled when start is accepted
//   out_valid/ready   beat handshake
//   mulA, mulB        per-lane zero-extended segments
//   lane_vld/i/j/dbl  per-lane pair description
//   last, done        final beat marker, end-of-operation pulse
// Revision    : 1.0  initial release
// ============================================================================
interface sq_operand_sched_if #(
  parameter int NSEG    = 4,
  parameter int SEG_DIG = 32,
  parameter int DIG_W   = 17,
  parameter int A_W     = 25,
  parameter int B_W     = 18,
  parameter int LANES   = 2
);
  localparam int c_ndig = NSEG * SEG_DIG + 1;
  localparam int c_iw   = (NSEG > 1) ? $clog2(NSEG) : 1;

  logic                                    start;
  logic                                    start_rdy;
  logic                                    op_sq;
  logic [c_ndig-1:0][DIG_W-1:0]            op_a;
  logic [c_ndig-1:0][DIG_W-1:0]            op_b;
  logic                                    out_valid;
  logic                                    out_ready;
  logic [LANES-1:0][SEG_DIG:0][A_W-1:0]    mulA;
  logic [LANES-1:0][SEG_DIG:0][B_W-1:0]    mulB;
  logic [LANES-1:0]                        lane_vld;
  logic [LANES-1:0][c_iw-1:0]              lane_i;
  logic [LANES-1:0][c_iw-1:0]              lane_j;
  logic [LANES-1:0]                        lane_dbl;
  logic                                    last;
  logic                                    done;

  modport slave (
    input  start, op_sq, op_a, op_b, out_ready,
    output start_rdy, out_valid, mulA, mulB, lane_vld, lane_i, lane_j, lane_dbl, last, done
  );

  modport master (
    output start, op_sq, op_a, op_b, out_ready,
    input  start_rdy, out_valid, mulA, mulB, lane_vld, lane_i, lane_j, lane_dbl, last, done
  );

endinterface
`default_nettype wire

// File: rtl/sq_operand_sched_seg_select.sv
`default_nettype none
// ============================================================================
// Module      : sq_seg_select
// Description : Combinational extraction of operand segment i_idx with
//               zero-extension of every digit to OUT_W bits. Slot SEG_DIG
//               carries the overlap digit for the top segment only.
//   i_op   [NDIG][DIG_W]        full operand
//   i_idx  [IW]                 segment index
//   i_en                        0 forces an all-zero segment
//   o_seg  [SEG_DIG+1][OUT_W]   extracted segment
// Revision    : 1.0  initial release
// ============================================================================
module sq_seg_select #(
  parameter int NSEG    = 4,
  parameter int SEG_DIG = 32,
  parameter int DIG_W   = 17,
  parameter int OUT_W   = 25,
  parameter int IW      = 2
) (
  input  logic [NSEG*SEG_DIG:0][DIG_W-1:0] i_op,
  input  logic [IW-1:0]                    i_idx,
  input  logic                             i_en,
  output logic [SEG_DIG:0][OUT_W-1:0]      o_seg
);
  localparam int c_ndig = NSEG * SEG_DIG + 1;
  localparam int c_pw   = $clog2(c_ndig);

  always_comb begin
    o_seg = '0;
    if (i_en) begin
      for (int s = 0; s < SEG_DIG; s++) begin
        o_seg[s] = OUT_W'(i_op[c_pw'(int'(i_idx) * SEG_DIG + s)]);
      end
      if (int'(i_idx) == NSEG - 1) begin
        o_seg[SEG_DIG] = OUT_W'(i_op[c_ndig-1]);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sq_operand_sched.sv
`default_nettype none
// ============================================================================
// Module      : sq_operand_sched
// Description : Captures operands on start, then issues segment pairs to
//               LANES multipliers, highest weight first, one beat per
//               out_valid&out_ready. Square mode issues the unique pairs and
//               marks i!=j lanes for doubling; multiply mode issues all pairs.
//   clk, rst_n   clock, asynchronous active-low reset
//   bus (slave)  start/operand handshake and beat-issue bus
// Revision    : 1.0  initial release
// ============================================================================
module sq_operand_sched
  import sq_sched_pkg::*;
#(
  parameter int NSEG    = 4,
  parameter int SEG_DIG = 32,
  parameter int DIG_W   = 17,
  parameter int A_W     = 25,
  parameter int B_W     = 18,
  parameter int LANES   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  sq_operand_sched_if.slave bus
);
  localparam int c_ndig  = NSEG * SEG_DIG + 1;
  localparam int c_iw    = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam int c_np_sq = npairs(NSEG, 1'b1);
  localparam int c_np_mu = npairs(NSEG, 1'b0);
  localparam int c_nb_sq = (c_np_sq + LANES - 1) / LANES;
  localparam int c_nb_mu = (c_np_mu + LANES - 1) / LANES;
  localparam int c_bw    = (c_nb_mu > 1) ? $clog2(c_nb_mu) : 1;

  if (A_W < DIG_W || B_W < DIG_W || NSEG < 1 || LANES < 1) begin : g_bad_param
    $error("sq_operand_sched: illegal parameter set");
  end

  sched_state_t                          r_state;
  logic [c_bw-1:0]                       r_beat;
  logic                                  r_sq;
  logic [c_ndig-1:0][DIG_W-1:0]          r_op_a;
  logic [c_ndig-1:0][DIG_W-1:0]          r_op_b;
  logic                                  r_valid;
  logic                                  r_last;
  logic [LANES-1:0]                      r_vld;
  logic [LANES-1:0]                      r_dbl;
  logic [LANES-1:0][c_iw-1:0]            r_i;
  logic [LANES-1:0][c_iw-1:0]            r_j;
  logic [LANES-1:0][SEG_DIG:0][A_W-1:0]  r_mul_a;
  logic [LANES-1:0][SEG_DIG:0][B_W-1:0]  r_mul_b;

  // Pair schedule per beat/lane, one table per mode, fixed at elaboration.
  logic                                  w_sq_vld [c_nb_mu][LANES];
  logic [c_iw-1:0]                       w_sq_i   [c_nb_mu][LANES];
  logic [c_iw-1:0]                       w_sq_j   [c_nb_mu][LANES];
  logic                                  w_mu_vld [c_nb_mu][LANES];
  logic [c_iw-1:0]                       w_mu_i   [c_nb_mu][LANES];
  logic [c_iw-1:0]                       w_mu_j   [c_nb_mu][LANES];

  logic                                  w_take_start;
  logic                                  w_accept;
  logic                                  w_load;
  logic                                  w_finish;
  logic                                  w_sq;
  logic [c_ndig-1:0][DIG_W-1:0]          w_src_a;
  logic [c_ndig-1:0][DIG_W-1:0]          w_src_b;
  logic [c_bw-1:0]                       w_ld_beat;
  logic [c_bw-1:0]                       w_nb_m1;
  logic [LANES-1:0]                      w_nxt_vld;
  logic [LANES-1:0]                      w_nxt_dbl;
  logic [LANES-1:0][c_iw-1:0]            w_nxt_i;
  logic [LANES-1:0][c_iw-1:0]            w_nxt_j;
  logic [LANES-1:0][SEG_DIG:0][A_W-1:0]  w_nxt_a;
  logic [LANES-1:0][SEG_DIG:0][B_W-1:0]  w_nxt_b;

  for (genvar b = 0; b < c_nb_mu; b++) begin : g_tab_beat
    for (genvar l = 0; l < LANES; l++) begin : g_tab_lane
      localparam int          c_idx = b * LANES + l;
      localparam logic [31:0] c_ps  = pair_at(c_idx, NSEG, 1'b1);
      localparam logic [31:0] c_pm  = pair_at(c_idx, NSEG, 1'b0);
      assign w_sq_vld[b][l] = (c_idx < c_np_sq);
      assign w_sq_i[b][l]   = c_iw'(c_ps[31:16]);
      assign w_sq_j[b][l]   = c_iw'(c_ps[15:0]);
      assign w_mu_vld[b][l] = (c_idx < c_np_mu);
      assign w_mu_i[b][l]   = c_iw'(c_pm[31:16]);
      assign w_mu_j[b][l]   = c_iw'(c_pm[15:0]);
    end
  end

  // out_valid is high for the whole of ISSUE, so ready alone accepts a beat.
  assign w_take_start = (r_state == c_st_idle) & bus.start;
  assign w_accept     = (r_state == c_st_issue) & bus.out_ready;
  assign w_load       = w_take_start | (w_accept & ~r_last);
  assign w_finish     = w_accept & r_last;

  // On the start cycle the first beat is built straight from the ports so it
  // can be presented on the very next cycle.
  assign w_sq      = w_take_start ? bus.op_sq : r_sq;
  assign w_src_a   = w_take_start ? bus.op_a : r_op_a;
  assign w_src_b   = w_take_start ? (bus.op_sq ? bus.op_a : bus.op_b) : r_op_b;
  assign w_ld_beat = w_take_start ? '0 : r_beat + 1'b1;
  assign w_nb_m1   = w_sq ? c_bw'(c_nb_sq - 1) : c_bw'(c_nb_mu - 1);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign w_nxt_vld[l] = w_sq ? w_sq_vld[w_ld_beat][l] : w_mu_vld[w_ld_beat][l];
    assign w_nxt_i[l]   = w_sq ? w_sq_i[w_ld_beat][l]   : w_mu_i[w_ld_beat][l];
    assign w_nxt_j[l]   = w_sq ? w_sq_j[w_ld_beat][l]   : w_mu_j[w_ld_beat][l];
    assign w_nxt_dbl[l] = w_sq & w_nxt_vld[l] & (w_nxt_i[l] != w_nxt_j[l]);

    sq_seg_select #(
      .NSEG    (NSEG),
      .SEG_DIG (SEG_DIG),
      .DIG_W   (DIG_W),
      .OUT_W   (A_W),
      .IW      (c_iw)
    ) u_sel_a (
      .i_op  (w_src_a),
      .i_idx (w_nxt_i[l]),
      .i_en  (w_nxt_vld[l]),
      .o_seg (w_nxt_a[l])
    );

    sq_seg_select #(
      .NSEG    (NSEG),
      .SEG_DIG (SEG_DIG),
      .DIG_W   (DIG_W),
      .OUT_W   (B_W),
      .IW      (c_iw)
    ) u_sel_b (
      .i_op  (w_src_b),
      .i_idx (w_nxt_j[l]),
      .i_en  (w_nxt_vld[l]),
      .o_seg (w_nxt_b[l])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
      r_beat  <= '0;
      r_sq    <= 1'b0;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_vld   <= '0;
      r_dbl   <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_mul_a <= '0;
      r_mul_b <= '0;
    end else begin
      case (r_state)
        c_st_idle:  if (bus.start) r_state <= c_st_issue;
        c_st_issue: if (w_finish)  r_state <= c_st_done;
        c_st_done:  r_state <= c_st_idle;
        default:    r_state <= c_st_idle;
      endcase

      if (w_take_start) begin
        r_sq   <= bus.op_sq;
        r_op_a <= bus.op_a;
        r_op_b <= w_src_b;
      end

      // Beat index only advances on a load, so it never wraps past the end.
      if (w_load) begin
        r_valid <= 1'b1;
        r_beat  <= w_ld_beat;
        r_last  <= (w_ld_beat == w_nb_m1);
        r_vld   <= w_nxt_vld;
        r_dbl   <= w_nxt_dbl;
        r_i     <= w_nxt_i;
        r_j     <= w_nxt_j;
        r_mul_a <= w_nxt_a;
        r_mul_b <= w_nxt_b;
      end else if (w_finish) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
        r_vld   <= '0;
        r_dbl   <= '0;
        r_i     <= '0;
        r_j     <= '0;
        r_mul_a <= '0;
        r_mul_b <= '0;
      end
    end
  end

  assign bus.start_rdy = (r_state == c_st_idle);
  assign bus.done      = (r_state == c_st_done);
  assign bus.out_valid = r_valid;
  assign bus.last      = r_last;
  assign bus.lane_vld  = r_vld;
  assign bus.lane_dbl  = r_dbl;
  assign bus.lane_i    = r_i;
  assign bus.lane_j    = r_j;
  assign bus.mulA      = r_mul_a;
  assign bus.mulB      = r_mul_b;

endmodule
`default_nettype wire
